// File: rtl/logic_arbiter.sv
// ---------------------------------------------------------------------------
// logic_arbiter
//
// Two-requester arbiter in front of one shared logic_unit. A request is
// accepted in IDLE, computed during a single EXEC cycle and then held in
// RESP until the granted requester consumes the result.
//
// Also defines:
//   alu_defs   - package with the 3-bit logic_unit opcodes
//   logic_unit - combinational N-bit logic/shift datapath
//
// Ports (logic_arbiter):
//   clk_i         in   1     clock, all state on rising edge
//   rst_ni        in   1     asynchronous active-low reset
//   req_valid_i   in   2     request valid, bit k = requester k
//   req_ready_o   out  2     request accepted (combinational, IDLE only)
//   req_a_i       in   2*N   operand A, requester k in [k*N +: N]
//   req_b_i       in   2*N   operand B / shift amount, same packing
//   req_op_i      in   6     opcode, requester k in [k*3 +: 3]
//   rsp_valid_o   out  2     result valid, bit k = requester k
//   rsp_ready_i   in   2     result consumed, bit k = requester k
//   rsp_result_o  out  N     registered result shared by both requesters
//   busy_o        out  1     high while in EXEC or RESP
//
// Configuration macro:
//   LOGIC_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins a tie
//                             and no last-grant pointer exists; otherwise
//                             ties are resolved round-robin.
// ---------------------------------------------------------------------------

package alu_defs;
    localparam logic [2:0] LOGIC_AND    = 3'd0;
    localparam logic [2:0] LOGIC_OR     = 3'd1;
    localparam logic [2:0] LOGIC_XOR    = 3'd2;
    localparam logic [2:0] LOGIC_NOT    = 3'd3;
    localparam logic [2:0] LOGIC_SHIFTL = 3'd4;
    localparam logic [2:0] LOGIC_SHIFTR = 3'd5;
    // Codes 6 and 7 are unused and produce a zero result.
endpackage

module logic_unit #(
    parameter int N = 4
) (
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result
);
    import alu_defs::*;

    // N held one bit wider so a shift amount equal to N is representable.
    localparam logic [N:0] N_VAL = (N+1)'(N);

    logic shift_in_range;
    assign shift_in_range = ({1'b0, b} < N_VAL);

    // Shifts by N or more return zero rather than wrapping the amount.
    always_comb begin
        result = '0;
        case (op)
            LOGIC_AND:    result = a & b;
            LOGIC_OR:     result = a | b;
            LOGIC_XOR:    result = a ^ b;
            LOGIC_NOT:    result = ~a;
            LOGIC_SHIFTL: result = shift_in_range ? (a << b) : '0;
            LOGIC_SHIFTR: result = shift_in_range ? (a >> b) : '0;
            default:      result = '0;
        endcase
    end
endmodule

module logic_arbiter #(
    parameter int N = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [1:0]     req_valid_i,
    output logic [1:0]     req_ready_o,
    input  logic [2*N-1:0] req_a_i,
    input  logic [2*N-1:0] req_b_i,
    input  logic [5:0]     req_op_i,
    output logic [1:0]     rsp_valid_o,
    input  logic [1:0]     rsp_ready_i,
    output logic [N-1:0]   rsp_result_o,
    output logic           busy_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state;
    logic         grant_q;
    logic         grant_sel;
    logic [N-1:0] op_a_q;
    logic [N-1:0] op_b_q;
    logic [2:0]   op_code_q;
    logic [N-1:0] lu_result;
    logic [N-1:0] sel_a;
    logic [N-1:0] sel_b;
    logic [2:0]   sel_op;

`ifndef LOGIC_ARB_FIXED_PRIO_EN
    logic         last_grant_q;
`endif

    // Winner among the currently valid requesters. With a single valid
    // requester it wins outright; ~req_valid_i[0] picks requester 1 exactly
    // when requester 0 is idle.
    always_comb begin
`ifdef LOGIC_ARB_FIXED_PRIO_EN
        grant_sel = ~req_valid_i[0];
`else
        grant_sel = (&req_valid_i) ? ~last_grant_q : ~req_valid_i[0];
`endif
    end

    // Ready is combinational so the requester sees acceptance in the same
    // cycle; it is also forced low while reset is held.
    always_comb begin
        req_ready_o = 2'b00;
        if (rst_ni && (state == IDLE) && (|req_valid_i)) begin
            req_ready_o = grant_sel ? 2'b10 : 2'b01;
        end
    end

    assign sel_a  = grant_sel ? req_a_i[2*N-1:N] : req_a_i[N-1:0];
    assign sel_b  = grant_sel ? req_b_i[2*N-1:N] : req_b_i[N-1:0];
    assign sel_op = grant_sel ? req_op_i[5:3]    : req_op_i[2:0];

    // The datapath sees only the captured operands, never the live inputs.
    logic_unit #(.N(N)) u_logic_unit (
        .op     (op_code_q),
        .a      (op_a_q),
        .b      (op_b_q),
        .result (lu_result)
    );

    // Control FSM with registered response outputs. Reset abandons any
    // in-flight operation without emitting a response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            grant_q      <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_code_q    <= '0;
            rsp_valid_o  <= 2'b00;
            rsp_result_o <= '0;
            busy_o       <= 1'b0;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid_i) begin
                        grant_q   <= grant_sel;
                        op_a_q    <= sel_a;
                        op_b_q    <= sel_b;
                        op_code_q <= sel_op;
                        busy_o    <= 1'b1;
                        state     <= EXEC;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
                        last_grant_q <= grant_sel;
`endif
                    end
                end
                EXEC: begin
                    rsp_result_o <= lu_result;
                    rsp_valid_o  <= grant_q ? 2'b10 : 2'b01;
                    state        <= RESP;
                end
                RESP: begin
                    // Only the granted requester's ready can end the response.
                    if (rsp_ready_i[grant_q]) begin
                        rsp_valid_o <= 2'b00;
                        busy_o      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_o <= 2'b00;
                    busy_o      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_logic_arbiter.sv
// ---------------------------------------------------------------------------
// tb_logic_arbiter
//
// Self-checking bench for logic_arbiter (N=4). Every cycle the DUT outputs
// are compared with a transaction-level reference model: one operation in
// flight, result computed arithmetically from the opcode rules, response
// expected two cycles after acceptance and held until the granted
// requester's ready. Directed scenarios run first, then randomized traffic.
// Honours LOGIC_ARB_FIXED_PRIO_EN for the expected tie-break.
// ---------------------------------------------------------------------------

module tb_logic_arbiter;
    import alu_defs::*;

    localparam int N    = 4;
    localparam int MASK = (1 << N) - 1;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic [1:0]     req_valid_i = '0;
    logic [1:0]     req_ready_o;
    logic [2*N-1:0] req_a_i = '0;
    logic [2*N-1:0] req_b_i = '0;
    logic [5:0]     req_op_i = '0;
    logic [1:0]     rsp_valid_o;
    logic [1:0]     rsp_ready_i = '0;
    logic [N-1:0]   rsp_result_o;
    logic           busy_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: whether an operation is outstanding, how many
    // cycles since it was accepted, who owns it and what it must return.
    bit m_inflight = 1'b0;
    int m_age      = 0;
    int m_gnt      = 0;
    int m_res      = 0;
    int m_shown    = 0;
    int m_last     = 1;
    int m_accepted = -1;

    logic_arbiter #(.N(N)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .req_op_i     (req_op_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_result_o (rsp_result_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Expected logic_unit result from the opcode definitions.
    function automatic int refResult(input logic [2:0] op, input int a, input int b);
        case (op)
            LOGIC_AND:    return a & b;
            LOGIC_OR:     return a | b;
            LOGIC_XOR:    return a ^ b;
            LOGIC_NOT:    return (~a) & MASK;
            LOGIC_SHIFTL: return (b < N) ? ((a << b) & MASK) : 0;
            LOGIC_SHIFTR: return (b < N) ? (a >> b) : 0;
            default:      return 0;
        endcase
    endfunction

    // Who should win given the valid bits and the previous grant.
    function automatic int pickWinner(input logic [1:0] v);
        if (v == 2'b11) begin
`ifdef LOGIC_ARB_FIXED_PRIO_EN
            return 0;
`else
            return 1 - m_last;
`endif
        end
        return v[0] ? 0 : 1;
    endfunction

    // Drive one cycle of inputs, compare all outputs against the model,
    // then advance the model to the next clock edge.
    task automatic applyStimulus(input logic [1:0] v, input logic [2*N-1:0] a,
                                 input logic [2*N-1:0] b, input logic [5:0] op,
                                 input logic [1:0] rr);
        int w;
        logic [1:0] exp_ready;
        logic [1:0] exp_valid;
        @(posedge clk_i);
        #1;
        req_valid_i = v;
        req_a_i     = a;
        req_b_i     = b;
        req_op_i    = op;
        rsp_ready_i = rr;
        @(negedge clk_i);
        m_accepted = -1;
        if (!m_inflight) begin
            exp_ready = (v != 2'b00) ? 2'(1 << pickWinner(v)) : 2'b00;
            exp_valid = 2'b00;
        end else begin
            exp_ready = 2'b00;
            exp_valid = (m_age >= 2) ? 2'(1 << m_gnt) : 2'b00;
        end
        checkOutput("req_ready", 32'(req_ready_o), 32'(exp_ready));
        checkOutput("rsp_valid", 32'(rsp_valid_o), 32'(exp_valid));
        checkOutput("busy", 32'(busy_o), 32'(m_inflight));
        checkOutput("rsp_result", 32'(rsp_result_o), 32'(m_shown));
        if (!m_inflight) begin
            if (v != 2'b00) begin
                w          = pickWinner(v);
                m_inflight = 1'b1;
                m_age      = 1;
                m_gnt      = w;
                m_res      = refResult(op[w*3 +: 3], int'(a[w*N +: N]), int'(b[w*N +: N]));
                m_last     = w;
                m_accepted = w;
            end
        end else if (m_age == 1) begin
            m_age   = 2;
            m_shown = m_res;
        end else if (rr[m_gnt]) begin
            m_inflight = 1'b0;
        end
    endtask

    // Assert reset mid-cycle, confirm every output clears, then release.
    task automatic doReset();
        @(posedge clk_i);
        #1;
        rst_ni      = 1'b0;
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b00;
        #2;
        checkOutput("reset_ready", 32'(req_ready_o), 32'd0);
        checkOutput("reset_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("reset_result", 32'(rsp_result_o), 32'd0);
        checkOutput("reset_busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        checkOutput("reset_valid_held", 32'(rsp_valid_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni     = 1'b1;
        m_inflight = 1'b0;
        m_shown    = 0;
        m_last     = 1;
    endtask

    // One complete operation from requester k with an immediate handshake.
    task automatic runOp(input int k, input logic [N-1:0] av, input logic [N-1:0] bv,
                         input logic [2:0] opv, input logic [N-1:0] expv, input string tag);
        logic [2*N-1:0] ap;
        logic [2*N-1:0] bp;
        logic [5:0]     opp;
        logic [1:0]     oh;
        ap = '0;
        bp = '0;
        opp = '0;
        ap[k*N +: N] = av;
        bp[k*N +: N] = bv;
        opp[k*3 +: 3] = opv;
        oh = 2'(1 << k);
        applyStimulus(oh, ap, bp, opp, 2'b00);
        checkOutput({tag, "_ready"}, 32'(req_ready_o), 32'(oh));
        applyStimulus(2'b00, ap, bp, opp, 2'b00);
        checkOutput({tag, "_exec_valid"}, 32'(rsp_valid_o), 32'd0);
        applyStimulus(2'b00, ap, bp, opp, oh);
        checkOutput({tag, "_valid"}, 32'(rsp_valid_o), 32'(oh));
        checkOutput({tag, "_result"}, 32'(rsp_result_o), 32'(expv));
    endtask

    logic [1:0]   exp_grants [4];
    bit           pend [2];
    logic [N-1:0] pa   [2];
    logic [N-1:0] pb   [2];
    logic [2:0]   pop  [2];

    initial begin
`ifdef LOGIC_ARB_FIXED_PRIO_EN
        exp_grants = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_grants = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        doReset();

        // Basic AND from requester 0, response two cycles after acceptance.
        runOp(0, 4'hC, 4'hA, LOGIC_AND, 4'h8, "and");

        // Both requesting continuously: tie-break sequence from reset.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, 8'h5A, 8'h3C, {LOGIC_OR, LOGIC_XOR}, 2'b11);
            checkOutput("tie_grant", 32'(req_ready_o), 32'(exp_grants[i]));
            applyStimulus(2'b11, 8'h5A, 8'h3C, {LOGIC_OR, LOGIC_XOR}, 2'b11);
            applyStimulus(2'b11, 8'h5A, 8'h3C, {LOGIC_OR, LOGIC_XOR}, 2'b11);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b00, '0, '0, '0, 2'b11);
        end

        // Requester 1 shift-left held in RESP while requester 0 waits and
        // requester 0's ready (not the owner) is high.
        applyStimulus(2'b10, {4'h3, 4'hF}, {4'h1, 4'hF}, {LOGIC_SHIFTL, LOGIC_AND}, 2'b00);
        checkOutput("hold_accept", 32'(req_ready_o), 32'b10);
        applyStimulus(2'b01, {4'h3, 4'hF}, {4'h1, 4'hF}, {LOGIC_SHIFTL, LOGIC_AND}, 2'b01);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b01, {4'h3, 4'hF}, {4'h1, 4'hF}, {LOGIC_SHIFTL, LOGIC_AND}, 2'b01);
            checkOutput("hold_result", 32'(rsp_result_o), 32'h6);
            checkOutput("hold_busy", 32'(busy_o), 32'd1);
            checkOutput("hold_ready", 32'(req_ready_o), 32'd0);
        end
        applyStimulus(2'b01, {4'h3, 4'hF}, {4'h1, 4'hF}, {LOGIC_SHIFTL, LOGIC_AND}, 2'b10);
        applyStimulus(2'b01, {4'h3, 4'hF}, {4'h1, 4'hF}, {LOGIC_SHIFTL, LOGIC_AND}, 2'b00);
        checkOutput("held_req_accept", 32'(req_ready_o), 32'b01);
        applyStimulus(2'b00, '0, '0, '0, 2'b00);
        applyStimulus(2'b00, '0, '0, '0, 2'b01);
        checkOutput("held_req_result", 32'(rsp_result_o), 32'hF);

        // Out-of-range shift and undefined opcode both give zero.
        runOp(0, 4'hF, 4'h4, LOGIC_SHIFTR, 4'h0, "shr_oob");
        runOp(0, 4'h5, 4'h0, LOGIC_OR, 4'h5, "or");
        runOp(1, 4'hF, 4'hF, 3'd6, 4'h0, "undef_op");

        // Reset while the operation is in EXEC: no response, then recover.
        applyStimulus(2'b01, 8'h0C, 8'h0A, {3'd0, LOGIC_AND}, 2'b00);
        doReset();
        applyStimulus(2'b00, '0, '0, '0, 2'b11);
        checkOutput("post_reset_valid", 32'(rsp_valid_o), 32'd0);
        runOp(0, 4'h5, 4'hF, LOGIC_XOR, 4'hA, "xor");

        // Randomized traffic: each requester holds its request until granted.
        pend = '{1'b0, 1'b0};
        for (int c = 0; c < 400; c++) begin
            logic [1:0]     v;
            logic [2*N-1:0] a;
            logic [2*N-1:0] b;
            logic [5:0]     op;
            if (c == 200) begin
                doReset();
            end
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && ($urandom_range(0, 2) == 0)) begin
                    pend[k] = 1'b1;
                    pa[k]   = N'($urandom);
                    pb[k]   = N'($urandom_range(0, N + 1));
                    pop[k]  = 3'($urandom_range(0, 7));
                end
            end
            v  = {pend[1], pend[0]};
            a  = {pa[1], pa[0]};
            b  = {pb[1], pb[0]};
            op = {pop[1], pop[0]};
            applyStimulus(v, a, b, op, 2'($urandom_range(0, 3)));
            if (m_accepted >= 0) begin
                pend[m_accepted] = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/logic_arbiter.md
LOGIC_ARBITER -- requirements
Module: logic_arbiter

Interface
REQ-001 Parameter: N, default 4, operand and result width in bits.
REQ-002 clk_i  input  1  single clock; all state on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid_i  input  2  request valid, bit k = requester k.
REQ-005 req_ready_o  output  2  request accepted, bit k = requester k.
REQ-006 req_a_i  input  2*N  operand A; requester k in bits [k*N +: N].
REQ-007 req_b_i  input  2*N  operand B / shift amount; same packing.
REQ-008 req_op_i  input  6  opcode per alu_defs.sv; requester k in bits [k*3 +: 3].
REQ-009 rsp_valid_o  output  2  result valid, bit k = requester k.
REQ-010 rsp_ready_i  input  2  result consumed, bit k = requester k.
REQ-011 rsp_result_o  output  N  registered result, shared by both requesters.
REQ-012 busy_o  output  1  high in EXEC and RESP states.

Function
REQ-013 Block SHALL instantiate one logic_unit #(N) as the shared datapath, fed only from internal operand registers.
REQ-014 FSM SHALL have states IDLE, EXEC, RESP; reset state IDLE.
REQ-015 IDLE: if any req_valid_i bit is high, SHALL select grant g, assert req_ready_o[g] combinationally that cycle, capture a/b/op of g, then go to EXEC.
REQ-016 req_ready_o SHALL be one-hot or zero, and zero outside IDLE.
REQ-017 EXEC: SHALL last exactly one cycle, register logic_unit output into rsp_result_o, then go to RESP.
REQ-018 RESP: rsp_valid_o[g] SHALL be high and rsp_result_o stable until rsp_ready_i[g]; on that handshake, SHALL go to IDLE.
REQ-019 rsp_ready_i of the non-granted requester SHALL be ignored.
REQ-020 Latency: request accepted at edge T SHALL produce rsp_valid_o at T+2; minimum 3 cycles per operation.
REQ-021 Arbitration (default): round-robin; when both are valid, the requester not granted last SHALL win; the last-grant pointer SHALL update on each request acceptance.
REQ-022 A single valid requester SHALL be granted regardless of the pointer.
REQ-023 Unused/undefined opcodes SHALL return result 0; shift amounts >= N SHALL return 0 (logic_unit semantics, unchanged).
REQ-024 A request arriving in EXEC/RESP SHALL wait with ready low; the block SHALL NOT drop or reorder a held request.

Reset
REQ-025 On rst_ni low: state IDLE, req_ready_o=0, rsp_valid_o=0, rsp_result_o=0, busy_o=0, operand registers 0, last-grant pointer = 1 (requester 0 wins first tie).
REQ-026 Reset mid-operation SHALL abandon the in-flight operation with no response issued.

Configuration
REQ-027 Macro LOGIC_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win simultaneous requests and the last-grant pointer SHALL be removed; when undefined, round-robin per REQ-021.

Verification
REQ-028 N=4, req0 op=LOGIC_AND a=4'hC b=4'hA -> req_ready_o=2'b01 at T, rsp_valid_o=2'b01 at T+2, rsp_result_o=4'h8.
REQ-029 Both valid every cycle, rsp_ready_i=2'b11, 4 operations -> grants 0,1,0,1 (round-robin); with LOGIC_ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-030 req1 op=LOGIC_SHIFTL a=4'h3 b=4'h1, rsp_ready_i[1] held low 5 cycles -> rsp_result_o=4'h6 stable, busy_o=1, req_ready_o=0 throughout.
REQ-031 req0 op=LOGIC_SHIFTR a=4'hF b=4'h4 -> result 4'h0; undefined opcode -> 4'h0.
REQ-032 rst_ni low during EXEC -> next cycle all outputs 0, no rsp_valid_o; a subsequent req0 LOGIC_XOR a=4'h5 b=4'hF -> 4'hA.
